// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  // RUN: normal issue. BUSY: a multi-cycle MDU op is parked in EX.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // EX jump-type encodings; 2'b11 is reserved and behaves like JUMP_NONE.
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. x0 never creates a dependency.
module hazard_detect (
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  output logic       o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_mem_read & (i_ex_rd != 5'd0) & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: merges EX redirects, ID load-use hazards and
// multi-cycle MDU ops into per-stage enables/flushes, runs the MDU start/wait
// handshake with a watchdog, and keeps saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic [1:0]       jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mdu_op,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_freeze,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int               WD_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WD_W-1:0]  r_wdog;
  logic [WD_W-1:0]  w_wdog_nxt;
  logic             r_err;
  logic             w_err_set;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_redirect;
  logic             w_load_use;

  hazard_detect u_hazard_detect (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .o_load_use    (w_load_use)
  );

  assign w_redirect = (branch & branch_taken) | (jump == JUMP_JAL) | (jump == JUMP_JALR);

  // State, watchdog and sticky error register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_wdog  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Mealy next-state and per-stage control; reset forces the flush pattern
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_err_set   = 1'b0;
    w_flush_evt = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_freeze   = 1'b0;
    mdu_start   = 1'b0;
    mdu_abort   = 1'b0;
    if (rst_i) begin
      w_state_nxt = ST_RUN;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_mdu_op) begin
            mdu_start   = 1'b1;
            ex_freeze   = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            w_state_nxt = ST_BUSY;
            w_wdog_nxt  = '0;
          end else if (w_redirect) begin
            // Redirect squashes any load-use dependent sitting in ID
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            w_flush_evt = 1'b1;
          end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            id_flush    = 1'b1;
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            // Done wins over a same-cycle watchdog expiry
            w_state_nxt = ST_RUN;
          end else if (r_wdog == WD_LAST) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            mdu_abort   = 1'b1;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            w_err_set   = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ex_freeze   = 1'b1;
            w_wdog_nxt  = r_wdog + 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign err_timeout = r_err;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO   = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_i, branch, branch_taken, ex_mem_read;
  logic [1:0]       jump;
  logic [4:0]       ex_rd, id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2, ex_mdu_op, mdu_done;
  logic             pc_write, ifid_write, if_flush, id_flush, ex_freeze;
  logic             mdu_start, mdu_abort, err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .branch(branch), .branch_taken(branch_taken),
    .jump(jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done), .pc_write(pc_write),
    .ifid_write(ifid_write), .if_flush(if_flush), .id_flush(id_flush),
    .ex_freeze(ex_freeze), .mdu_start(mdu_start), .mdu_abort(mdu_abort),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: are we waiting on the MDU, for how many cycles, plus counters
  bit m_busy = 0;
  bit m_err = 0;
  int m_wait = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit e_pc, e_ifid, e_iff, e_idf, e_frz, e_start, e_abort, e_redir_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current inputs from the rules, not the encoding
  task automatic eval_model();
    bit redir, lu;
    redir = (branch && branch_taken) || (jump == 2'd1) || (jump == 2'd2);
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifid, e_iff, e_idf, e_frz, e_start, e_abort, e_redir_cnt} = '0;
    if (rst_i) begin
      e_iff = 1; e_idf = 1;
    end else if (!m_busy) begin
      if (ex_mdu_op) begin
        e_start = 1; e_frz = 1;
      end else if (redir) begin
        e_pc = 1; e_ifid = 1; e_iff = 1; e_idf = 1; e_redir_cnt = 1;
      end else if (lu) begin
        e_idf = 1;
      end else begin
        e_pc = 1; e_ifid = 1;
      end
    end else if (mdu_done) begin
      e_pc = 1; e_ifid = 1;
    end else if (m_wait + 1 == TMO) begin
      e_abort = 1; e_iff = 1; e_idf = 1;
    end else begin
      e_frz = 1;
    end
  endtask

  task automatic drive(input logic r, b, t, input logic [1:0] j, input logic mr,
                       input logic [4:0] rd, r1, r2, input logic u1, u2, mo, dn);
    @(negedge clk_i);
    rst_i = r; branch = b; branch_taken = t; jump = j; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mdu_op = mo; mdu_done = dn;
    #1;
    eval_model();
    chk("pc_write", 32'(pc_write), 32'(e_pc));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifid));
    chk("if_flush", 32'(if_flush), 32'(e_iff));
    chk("id_flush", 32'(id_flush), 32'(e_idf));
    chk("ex_freeze", 32'(ex_freeze), 32'(e_frz));
    chk("mdu_start", 32'(mdu_start), 32'(e_start));
    chk("mdu_abort", 32'(mdu_abort), 32'(e_abort));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) begin
      m_busy = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (e_redir_cnt && m_flush < CMAX) m_flush++;
      if (!m_busy) begin
        if (ex_mdu_op) begin m_busy = 1; m_wait = 0; end
      end else if (mdu_done) begin
        m_busy = 0;
      end else if (m_wait + 1 == TMO) begin
        m_busy = 0; m_err = 1;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic idle_step(input logic r);
    drive(r, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_step(1); advance();
    idle_step(1); advance();
  endtask

  int starts;

  initial begin
    rst_i = 1; branch = 0; branch_taken = 0; jump = 0; ex_mem_read = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mdu_op = 0; mdu_done = 0;

    // Reset outputs
    idle_step(1);
    chk("rst pc_write", 32'(pc_write), 0);
    chk("rst if_flush", 32'(if_flush), 1);
    chk("rst id_flush", 32'(id_flush), 1);
    chk("rst ex_freeze", 32'(ex_freeze), 0);
    advance();

    // T1: lw x5 / add x5 -> one stall cycle
    idle_step(1); advance();
    drive(0, 0, 0, 2'd0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
    chk("T1 pc_write", 32'(pc_write), 0);
    chk("T1 ifid_write", 32'(ifid_write), 0);
    chk("T1 id_flush", 32'(id_flush), 1);
    advance();
    idle_step(0);
    chk("T1 stall_cnt", 32'(stall_cnt), 1);
    advance();

    // T2: x0 never hazards
    do_reset();
    drive(0, 0, 0, 2'd0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    chk("T2 pc_write", 32'(pc_write), 1);
    chk("T2 id_flush", 32'(id_flush), 0);
    advance();

    // T3: taken branch beats load-use
    do_reset();
    drive(0, 1, 1, 2'd0, 1, 5'd7, 5'd0, 5'd7, 0, 1, 0, 0);
    chk("T3 if_flush", 32'(if_flush), 1);
    chk("T3 id_flush", 32'(id_flush), 1);
    chk("T3 pc_write", 32'(pc_write), 1);
    advance();
    idle_step(0);
    chk("T3 flush_cnt", 32'(flush_cnt), 1);
    advance();

    // T4: MDU done on the TMO-th BUSY cycle (same cycle as expiry: done wins)
    do_reset();
    starts = 0;
    drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    starts += int'(mdu_start);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      starts += int'(mdu_start);
      chk("T4 ex_freeze", 32'(ex_freeze), 1);
      advance();
    end
    drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    starts += int'(mdu_start);
    chk("T4 done pc_write", 32'(pc_write), 1);
    chk("T4 done abort", 32'(mdu_abort), 0);
    advance();
    idle_step(0);
    chk("T4 starts", 32'(starts), 1);
    chk("T4 stall_cnt", 32'(stall_cnt), 6);
    chk("T4 err", 32'(err_timeout), 0);
    chk("T4 run", 32'(ex_freeze), 0);
    advance();

    // T5: watchdog abort on TMO-th BUSY cycle, sticky error
    do_reset();
    drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    advance();
    for (int i = 1; i <= TMO; i++) begin
      drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      chk("T5 abort", 32'(mdu_abort), (i == TMO) ? 1 : 0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      idle_step(0);
      chk("T5 err sticky", 32'(err_timeout), 1);
      advance();
    end
    idle_step(1); advance();
    idle_step(0);
    chk("T5 err cleared", 32'(err_timeout), 0);
    advance();

    // T6: reset mid-BUSY with a JAL present
    do_reset();
    drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0); advance();
    drive(0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0); advance();
    drive(1, 0, 0, 2'd1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    chk("T6 abort", 32'(mdu_abort), 0);
    chk("T6 pc_write", 32'(pc_write), 0);
    chk("T6 if_flush", 32'(if_flush), 1);
    advance();
    idle_step(0);
    chk("T6 run pc_write", 32'(pc_write), 1);
    chk("T6 stall_cnt", 32'(stall_cnt), 0);
    chk("T6 flush_cnt", 32'(flush_cnt), 0);
    advance();

    // Counter saturation
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(0, 0, 0, 2'd0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0); advance();
    end
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(0, 0, 0, 2'd2, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); advance();
    end
    idle_step(0);
    chk("sat stall_cnt", 32'(stall_cnt), CMAX);
    chk("sat flush_cnt", 32'(flush_cnt), CMAX);
    advance();

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] j;
      j = ($urandom_range(0, 7) < 5) ? 2'd0 : 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), j,
            1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
